// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing stage: debounced push-button request, WALK at red onset, flashing DON'T WALK.
// Optional lamp-bus supervisor with sticky FAULT state, built only when PED_FAULT_EN is defined.
module ped_crossing_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned WALK_CYCLES     = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic ped_btn,
  input  logic red,
  input  logic yellow,
  input  logic green,
  output logic walk,
  output logic dont_walk,
  output logic req_pending,
  output logic fault
);

  localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] DB_FULL   = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] WALK_LOAD = 8'(WALK_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RED,
    WALK,
`ifdef PED_FAULT_EN
    CLEAR,
    FAULT
`else
    CLEAR
`endif
  } state_t;

  state_t     state, state_n;
  logic       sync1, s;
  logic [7:0] db_cnt;
  logic [7:0] walk_cnt, walk_cnt_n;
  logic       press;
  logic       red_ok, red_q, red_rise;
  logic       walk_n, dont_walk_n, req_n;

  // Counter saturates at DEBOUNCE_CYCLES so a held button fires only once.
  assign press    = s && (db_cnt == DB_LAST);
  assign red_ok   = red & ~yellow & ~green;
  assign red_rise = red_ok & ~red_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      s      <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= ped_btn;
      s     <= sync1;
      if (!s)
        db_cnt <= '0;
      else if (db_cnt != DB_FULL)
        db_cnt <= db_cnt + 8'd1;
    end
  end

`ifdef PED_FAULT_EN
  logic illegal, illegal_q, fault_n;
  assign illegal = ~$onehot({red, yellow, green});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
      fault     <= 1'b0;
    end else begin
      illegal_q <= illegal;
      fault     <= fault_n;
    end
  end
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    walk_cnt_n = walk_cnt;
    req_n      = req_pending;
    case (state)
      IDLE: begin
        if ((req_pending || press) && red_rise)
          state_n = WALK;
        else if (req_pending)
          state_n = WAIT_RED;
      end
      WAIT_RED: if (red_rise) state_n = WALK;
      WALK: begin
        if (!red_ok)
          state_n = IDLE;
        else if (walk_cnt == 8'd1)
          state_n = CLEAR;
        else
          walk_cnt_n = walk_cnt - 8'd1;
      end
      CLEAR: if (!red_ok) state_n = IDLE;
`ifdef PED_FAULT_EN
      FAULT: state_n = FAULT;
`endif
      default: state_n = IDLE;
    endcase
`ifdef PED_FAULT_EN
    if (illegal && illegal_q)
      state_n = FAULT;
`endif

    if (press && state != WALK)
      req_n = 1'b1;
    if (state_n == WALK && state != WALK) begin
      walk_cnt_n = WALK_LOAD;
      req_n      = 1'b0;
    end
`ifdef PED_FAULT_EN
    if (state_n == FAULT)
      req_n = 1'b0;
    fault_n = (state_n == FAULT);
`endif

    walk_n = (state_n == WALK);
    case (state_n)
      WALK:    dont_walk_n = 1'b0;
      CLEAR:   dont_walk_n = (state == CLEAR) ? ~dont_walk : 1'b1;
      default: dont_walk_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      walk_cnt    <= '0;
      red_q       <= 1'b0;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      req_pending <= 1'b0;
    end else begin
      state       <= state_n;
      walk_cnt    <= walk_cnt_n;
      red_q       <= red_ok;
      walk        <= walk_n;
      dont_walk   <= dont_walk_n;
      req_pending <= req_n;
    end
  end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed self-checking bench for ped_crossing_ctrl (default parameters).
// Fault expectations follow PED_FAULT_EN when the bench is built with that macro.
module tb_ped_crossing_ctrl;

  logic clk = 1'b0;
  logic reset, ped_btn, red, yellow, green;
  logic walk, dont_walk, req_pending, fault;
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic fault_exp;

  ped_crossing_ctrl #(.DEBOUNCE_CYCLES(4), .WALK_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .ped_btn(ped_btn),
    .red(red), .yellow(yellow), .green(green),
    .walk(walk), .dont_walk(dont_walk), .req_pending(req_pending), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic lamps(input logic r, input logic y, input logic g);
    red = r; yellow = y; green = g;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic w, input logic dw, input logic rp);
    chk({tag, ".walk"}, walk, w);
    chk({tag, ".dont_walk"}, dont_walk, dw);
    chk({tag, ".req_pending"}, req_pending, rp);
  endtask

  task automatic press6;
    ped_btn = 1'b1;
    tick(5);
    chk("press_k4_rp", req_pending, 1'b0);
    tick(1);
    chk("press_k5_rp", req_pending, 1'b1);
    ped_btn = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef PED_FAULT_EN
    fault_exp = 1'b1;
`else
    fault_exp = 1'b0;
`endif
    reset = 1'b1; ped_btn = 1'b0;
    lamps(1'b0, 1'b0, 1'b1);
    tick(3);
    chk_out("reset", 1'b0, 1'b1, 1'b0);
    chk("reset.fault", fault, 1'b0);
    reset = 1'b0;
    tick(2);

    // Short press: 3 cycles high is below the debounce threshold
    ped_btn = 1'b1;
    tick(3);
    ped_btn = 1'b0;
    tick(6);
    chk("short_press_rp", req_pending, 1'b0);

    // Long press during green, then yellow, then 5 cycles of red
    press6();
    lamps(1'b0, 1'b1, 1'b0);
    tick(2);
    chk_out("yellow_wait", 1'b0, 1'b1, 1'b1);
    lamps(1'b1, 1'b0, 1'b0);
    tick(1);
    chk_out("walk_r0", 1'b1, 1'b0, 1'b0);
    tick(1);
    chk_out("walk_r1", 1'b1, 1'b0, 1'b0);
    tick(1);
    chk_out("walk_r2", 1'b1, 1'b0, 1'b0);
    tick(1);
    chk_out("clear_r3", 1'b0, 1'b1, 1'b0);
    tick(1);
    chk_out("clear_r4", 1'b0, 1'b0, 1'b0);
    lamps(1'b0, 1'b0, 1'b1);
    tick(1);
    chk_out("red_off_r5", 1'b0, 1'b1, 1'b0);
    tick(1);
    chk_out("red_off_r6", 1'b0, 1'b1, 1'b0);

    // Request made mid-red waits for the next red phase; then abort after 2 WALK cycles
    lamps(1'b1, 1'b0, 1'b0);
    tick(2);
    press6();
    tick(2);
    chk_out("midred_no_walk", 1'b0, 1'b1, 1'b1);
    lamps(1'b0, 1'b0, 1'b1);
    tick(2);
    chk_out("midred_green", 1'b0, 1'b1, 1'b1);
    lamps(1'b1, 1'b0, 1'b0);
    tick(1);
    chk_out("next_red_walk0", 1'b1, 1'b0, 1'b0);
    tick(1);
    chk_out("next_red_walk1", 1'b1, 1'b0, 1'b0);
    lamps(1'b0, 1'b0, 1'b1);
    tick(1);
    chk_out("abort", 1'b0, 1'b1, 1'b0);
    tick(1);
    chk_out("abort_idle", 1'b0, 1'b1, 1'b0);

    // Lamp-bus faults: 1-cycle illegal pattern is tolerated, 2 cycles latch FAULT
    lamps(1'b1, 1'b0, 1'b1);
    tick(1);
    chk("glitch1_fault", fault, 1'b0);
    lamps(1'b0, 1'b0, 1'b1);
    tick(1);
    chk("glitch1_after", fault, 1'b0);
    lamps(1'b1, 1'b0, 1'b1);
    tick(1);
    chk("illegal_edge1", fault, 1'b0);
    tick(1);
    chk("illegal_edge2", fault, fault_exp);
    chk("illegal_dw", dont_walk, 1'b1);
    lamps(1'b0, 1'b0, 1'b1);
    tick(3);
    chk("fault_sticky", fault, fault_exp);
    lamps(1'b1, 1'b0, 1'b0);
    tick(1);
    chk_out("fault_red", 1'b0, 1'b1, 1'b0);
    chk("fault_red.fault", fault, fault_exp);
    #2 reset = 1'b1;
    #1 chk("fault_reset", fault, 1'b0);
    @(negedge clk) reset = 1'b0;
    lamps(1'b0, 1'b0, 1'b1);
    tick(2);

    // Asynchronous reset mid-WALK drops walk immediately
    press6();
    tick(1);
    lamps(1'b1, 1'b0, 1'b0);
    tick(1);
    chk_out("walk_before_rst", 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 chk_out("async_rst", 1'b0, 1'b1, 1'b0);
    @(negedge clk) reset = 1'b0;
    tick(2);
    chk_out("after_rst", 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ped_crossing_ctrl.md
# ped_crossing_ctrl

Pedestrian crossing stage driven by the traffic light controller's `red`, `yellow` and `green` lamp outputs. It synchronises and debounces a pedestrian push-button and latches the request. It grants a WALK interval only at the start of a red phase, then flashes DON'T WALK until red ends. It also supervises the lamp bus for illegal lamp patterns.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive synchronised-high samples needed to accept a press (1..255).
- `WALK_CYCLES`, 3: cycles `walk` is held high per red phase (1..255).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `ped_btn` in 1: raw push-button, asynchronous to `clk`.
- `red`, `yellow`, `green` in 1 each: lamp outputs from the traffic light controller, synchronous to `clk`.
- `walk` out 1: WALK lamp.
- `dont_walk` out 1: DON'T WALK lamp, steady or flashing.
- `req_pending` out 1: request latched, not yet served.
- `fault` out 1: sticky lamp-bus fault.

## Operation
- Button path:
  - Two-flop synchroniser on `ped_btn` produces `s`.
  - An 8-bit counter counts consecutive cycles with `s`=1 and clears when `s`=0.
  - When the count reaches `DEBOUNCE_CYCLES`, exactly one press event fires. There is no re-arm until `s` returns low.
- A press event sets `req_pending`. It is cleared on entry to WALK, on entry to FAULT, or by reset.
- Qualified red: `red_ok = red & ~yellow & ~green`.
  - `red_q` is the registered `red_ok`.
  - `red_rise = red_ok & ~red_q`.
- FSM states:
  - IDLE: `dont_walk`=1 steady.
    - `req_pending` (or a same-cycle press event) with `red_rise` -> WALK.
    - `req_pending` without `red_rise` -> WAIT_RED.
  - WAIT_RED: `dont_walk`=1.
    - `red_rise` -> WALK.
    - A request made while red is already on waits for the next red phase.
  - WALK: `walk`=1, `dont_walk`=0, counter loaded with `WALK_CYCLES`.
    - Counter expiry with `red_ok` still 1 -> CLEAR.
    - `red_ok`=0 at any cycle -> IDLE (abort: `walk`=0, `dont_walk`=1 next cycle).
  - CLEAR: `walk`=0.
    - `dont_walk` is 1 on the first cycle, then toggles every cycle.
    - `red_ok`=0 -> IDLE with `dont_walk`=1 steady.
  - FAULT: `walk`=0, `dont_walk`=1, `fault`=1.
    - Exit only by reset.
- Press events during WALK are ignored. Press events during CLEAR or WAIT_RED set or hold `req_pending`.
- All outputs are registered. Reset values: `walk`=0, `dont_walk`=1, `req_pending`=0, `fault`=0, state IDLE, counters 0, synchroniser 0.
- Reset mid-WALK or mid-CLEAR drops `walk` immediately (asynchronously) and discards any pending request.

## Timing
- Button latency, with `ped_btn` rising before edge k:
  - `s`=1 after edge k+1.
  - `req_pending`=1 after edge k+1+`DEBOUNCE_CYCLES` (k+5 at default).
- WALK entry: `walk`=1 after the first edge at which `red_ok` is sampled 1 with `red_q`=0, i.e. one cycle after red turns on.
- WALK length is exactly `WALK_CYCLES` cycles unless aborted.
- CLEAR: `dont_walk` period is 2 cycles.
- Red off to IDLE: `dont_walk` steady 1 after the first edge sampling `red_ok`=0.

## Configuration
- Macro: `PED_FAULT_EN`.
- Defined:
  - A pattern that is not one-hot (none, or more than one of `red`/`yellow`/`green`) sampled on 2 consecutive edges -> FAULT on the second edge.
  - A single-cycle illegal pattern only deasserts `red_ok`.
- Undefined:
  - FAULT state and detector are not built.
  - `fault` is tied to 0.
  - Illegal patterns only act through `red_ok`=0.

## Test plan
- Reset asserted -> `walk`=0, `dont_walk`=1, `req_pending`=0, `fault`=0.
- `ped_btn` high for 3 cycles then low -> no press. High for 6 cycles -> `req_pending`=1 after edge k+5, exactly one event.
- Request during green; lamps then go red for 5 cycles -> `walk`=1 for 3 cycles starting 1 cycle after red rises, `req_pending` cleared. Then `dont_walk` toggles 1,0 until red drops, then steady 1.
- Request latched mid-red -> no walk in that red phase. Walk is granted at the next red rise.
- Red drops after 2 WALK cycles (`WALK_CYCLES`=3) -> `walk`=0, `dont_walk`=1 on the next cycle, state IDLE.
- With `PED_FAULT_EN`: `red`=`green`=1 for 1 cycle -> no fault. For 2 cycles -> `fault`=1 and `dont_walk`=1, persisting until reset. Without the macro, same stimulus -> `fault`=0.
